// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  // Word aligned and the whole word inside memory; 33-bit sum so high addresses cannot wrap.
  function automatic logic addr_legal(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] mem_bytes);
    logic [ADDR_W:0] w_end;
    w_end = {1'b0, addr} + {{ADDR_W{1'b0}}, 1'b0} + (ADDR_W+1)'(3);
    return (addr[1:0] == 2'b00) && (w_end < {1'b0, mem_bytes});
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker; the last-grant flop lives in the parent.
module rr_arb2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_winner,
  output logic o_valid
);

  always_comb begin
    o_valid  = i_req0 | i_req1;
    o_winner = i_req1;
    if (i_req0 && i_req1) o_winner = ~i_last;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the CPU MEM stage and the debug loader.
// Optional saturating grant/error counters are enabled by DMEM_ARB_STATS_EN.
//
// Handshake: a requester holds *_req_i until it sees its one-cycle *_gnt_o; exactly one
// *_rvalid_o pulse (with *_rdata_o/*_err_o) follows each grant, and nothing is queued.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ACCESS_LAT = 2,
  parameter int MEM_BYTES  = 120
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_err_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [31:0]       dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [31:0]       dbg_rdata_o,
  output logic              dbg_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  input  logic [31:0]       mem_rdata_i,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]       cpu_cnt_o,
  output logic [15:0]       dbg_cnt_o,
  output logic [15:0]       err_cnt_o,
`endif
  output logic              busy_o
);

  localparam logic [3:0] LP_BEAT_INIT = 4'(ACCESS_LAT - 1);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  owner_t            r_owner;
  owner_t            r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [3:0]        r_beat;
  logic              r_cpu_gnt;
  logic              r_dbg_gnt;

  logic              w_winner;
  logic              w_arb_valid;
  owner_t            w_win_owner;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic              w_sel_legal;
  logic              w_access;
  logic              w_resp;
  logic              w_last_beat;

  rr_arb2 u_rr_arb2 (
    .i_req0   (cpu_req_i),
    .i_req1   (dbg_req_i),
    .i_last   (r_last == OWN_DBG),
    .o_winner (w_winner),
    .o_valid  (w_arb_valid)
  );

  assign w_win_owner = w_winner ? OWN_DBG : OWN_CPU;

  always_comb begin
    w_sel_we    = cpu_we_i;
    w_sel_addr  = cpu_addr_i;
    w_sel_wdata = cpu_wdata_i;
    if (w_win_owner == OWN_DBG) begin
      w_sel_we    = dbg_we_i;
      w_sel_addr  = dbg_addr_i;
      w_sel_wdata = dbg_wdata_i;
    end
  end

  assign w_sel_legal = addr_legal(w_sel_addr, ADDR_W'(MEM_BYTES));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_arb_valid) w_state_nxt = w_sel_legal ? ACCESS : RESP;
      ACCESS:  if (r_beat == 4'd0) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_owner   <= OWN_CPU;
      r_last    <= OWN_DBG;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_beat    <= 4'd0;
      r_cpu_gnt <= 1'b0;
      r_dbg_gnt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cpu_gnt <= 1'b0;
      r_dbg_gnt <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_arb_valid) begin
            r_owner   <= w_win_owner;
            r_last    <= w_win_owner;
            r_we      <= w_sel_we;
            r_addr    <= w_sel_addr;
            r_wdata   <= w_sel_wdata;
            r_err     <= ~w_sel_legal;
            r_rdata   <= '0;
            r_beat    <= LP_BEAT_INIT;
            r_cpu_gnt <= (w_win_owner == OWN_CPU);
            r_dbg_gnt <= (w_win_owner == OWN_DBG);
          end
        end
        ACCESS: begin
          if (r_beat == 4'd0) begin
            if (!r_we) r_rdata <= mem_rdata_i;
          end else begin
            r_beat <= r_beat - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory strobes and response fields are gated so they read as zero outside their phase.
  assign w_access    = (r_state == ACCESS);
  assign w_resp      = (r_state == RESP);
  assign w_last_beat = w_access && (r_beat == 4'd0);

  assign mem_addr_o  = w_access ? r_addr  : '0;
  assign mem_data_o  = w_access ? r_wdata : '0;
  assign mem_read_o  = w_access & ~r_we;
  assign mem_write_o = w_last_beat & r_we;

  assign cpu_gnt_o    = r_cpu_gnt;
  assign dbg_gnt_o    = r_dbg_gnt;
  assign cpu_rvalid_o = w_resp && (r_owner == OWN_CPU);
  assign dbg_rvalid_o = w_resp && (r_owner == OWN_DBG);
  assign cpu_rdata_o  = cpu_rvalid_o ? r_rdata : '0;
  assign dbg_rdata_o  = dbg_rvalid_o ? r_rdata : '0;
  assign cpu_err_o    = cpu_rvalid_o & r_err;
  assign dbg_err_o    = dbg_rvalid_o & r_err;
  assign busy_o       = (r_state != IDLE);

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] r_cpu_cnt;
  logic [15:0] r_dbg_cnt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cpu_cnt <= 16'd0;
      r_dbg_cnt <= 16'd0;
      r_err_cnt <= 16'd0;
    end else begin
      if (r_cpu_gnt && (r_cpu_cnt != 16'hFFFF)) r_cpu_cnt <= r_cpu_cnt + 16'd1;
      if (r_dbg_gnt && (r_dbg_cnt != 16'hFFFF)) r_dbg_cnt <= r_dbg_cnt + 16'd1;
      if (w_resp && r_err && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign cpu_cnt_o = r_cpu_cnt;
  assign dbg_cnt_o = r_dbg_cnt;
  assign err_cnt_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed and random transactions scored against a
// transaction-level timing/data model; stats checks when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;

  localparam int LAT = 2;
  localparam int MB  = 120;
  localparam int NW  = MB / 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0, cpu_wdata_i = '0;
  logic        cpu_gnt_o, cpu_rvalid_o, cpu_err_o;
  logic [31:0] cpu_rdata_o;
  logic        dbg_req_i = 1'b0, dbg_we_i = 1'b0;
  logic [31:0] dbg_addr_i = '0, dbg_wdata_i = '0;
  logic        dbg_gnt_o, dbg_rvalid_o, dbg_err_o;
  logic [31:0] dbg_rdata_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_rdata_i;
  logic        mem_write_o, mem_read_o, busy_o;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] cpu_cnt_o, dbg_cnt_o, err_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: last granted port (0 = CPU, 1 = DBG), grant and error tallies.
  int m_last = 1;
  int m_gnt [2];
  int m_err = 0;

  // Per-case request description, indexed by port.
  bit          act_a [2];
  bit          we_a  [2];
  logic [31:0] addr_a[2];
  logic [31:0] wd_a  [2];

  // Environment memory: initial image overlaid by DUT writes; ref_mem is the model's view.
  logic [31:0]   init_mem [NW];
  logic [31:0]   wr_mem   [NW];
  logic [NW-1:0] wr_valid = '0;
  logic [31:0]   ref_mem  [NW];

  dmem_arbiter #(.ACCESS_LAT(LAT), .MEM_BYTES(MB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_req_i    (cpu_req_i),
    .cpu_we_i     (cpu_we_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_gnt_o    (cpu_gnt_o),
    .cpu_rvalid_o (cpu_rvalid_o),
    .cpu_rdata_o  (cpu_rdata_o),
    .cpu_err_o    (cpu_err_o),
    .dbg_req_i    (dbg_req_i),
    .dbg_we_i     (dbg_we_i),
    .dbg_addr_i   (dbg_addr_i),
    .dbg_wdata_i  (dbg_wdata_i),
    .dbg_gnt_o    (dbg_gnt_o),
    .dbg_rvalid_o (dbg_rvalid_o),
    .dbg_rdata_o  (dbg_rdata_o),
    .dbg_err_o    (dbg_err_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_write_o  (mem_write_o),
    .mem_read_o   (mem_read_o),
    .mem_rdata_i  (mem_rdata_i),
`ifdef DMEM_ARB_STATS_EN
    .cpu_cnt_o    (cpu_cnt_o),
    .dbg_cnt_o    (dbg_cnt_o),
    .err_cnt_o    (err_cnt_o),
`endif
    .busy_o       (busy_o)
  );

  // ---------------- clock / memory environment ----------------
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input int i);
    return wr_valid[i] ? wr_mem[i] : init_mem[i];
  endfunction

  always_comb begin
    mem_rdata_i = 32'h0;
    if (mem_addr_o < 32'(MB)) mem_rdata_i = mem_word(int'(mem_addr_o >> 2));
  end

  always @(posedge clk) begin
    if (mem_write_o && (mem_addr_o < 32'(MB))) begin
      wr_mem[int'(mem_addr_o >> 2)]   <= mem_data_o;
      wr_valid[int'(mem_addr_o >> 2)] <= 1'b1;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic string pn(input int p);
    return (p == 0) ? "cpu" : "dbg";
  endfunction

  function automatic logic legal(input logic [31:0] a);
    return (a % 4 == 0) && (longint'(a) + 3 < longint'(MB));
  endfunction

  function automatic logic [31:0] rand_addr();
    int c;
    c = $urandom_range(0, 9);
    if (c < 6)       return 32'($urandom_range(0, NW - 1)) * 4;
    else if (c == 6) return 32'($urandom_range(0, NW - 1)) * 4 + 32'($urandom_range(1, 3));
    else if (c == 7) return 32'($urandom_range(NW, NW + 10)) * 4;
    else if (c == 8) return 32'hFFFF_FFFC;
    else             return 32'($urandom_range(117, 119));
  endfunction

  task automatic setp(input int p, input bit on, input bit w, input logic [31:0] a,
                      input logic [31:0] d);
    act_a[p] = on; we_a[p] = w; addr_a[p] = a; wd_a[p] = d;
  endtask

  task automatic apply_inputs();
    cpu_req_i = act_a[0]; cpu_we_i = we_a[0]; cpu_addr_i = addr_a[0]; cpu_wdata_i = wd_a[0];
    dbg_req_i = act_a[1]; dbg_we_i = we_a[1]; dbg_addr_i = addr_a[1]; dbg_wdata_i = wd_a[1];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    setp(0, 0, 0, '0, '0);
    setp(1, 0, 0, '0, '0);
    apply_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_last = 1;
    m_gnt[0] = 0; m_gnt[1] = 0; m_err = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) check("idle_timeout", 64'(busy_o), 64'(0));
  endtask

  task automatic check_mem();
    int bad;
    bad = 0;
    for (int i = 0; i < NW; i++) if (mem_word(i) !== ref_mem[i]) bad++;
    check("mem_image", 64'(bad), 64'(0));
  endtask

  // ---------------- one arbitration round (one or two requesters) ----------------
  task automatic run_case();
    int          order[2];
    int          n, s;
    int          g_k[2], r_k[2];
    bit          e_ok[2];
    logic [31:0] e_rd[2];
    logic        e_err[2];
    int          o_g[2], o_r[2];
    logic [31:0] o_rd[2];
    logic        o_err[2];
    int          reads, e_reads, bad_idle, bad_zero, dup, extra_w;
    bit          in_acc;
    logic [71:0] exp_w_q[$];
    logic [71:0] w_ent;

    wait_idle();
    n = 0;
    if (act_a[0] && act_a[1]) begin
      order[0] = (m_last == 1) ? 0 : 1;
      order[1] = 1 - order[0];
      n = 2;
    end else if (act_a[0] || act_a[1]) begin
      order[0] = act_a[0] ? 0 : 1;
      n = 1;
    end
    for (int p = 0; p < 2; p++) begin
      g_k[p] = -1; r_k[p] = -1; e_ok[p] = 0; e_rd[p] = '0; e_err[p] = 0;
      o_g[p] = -1; o_r[p] = -1; o_rd[p] = '0; o_err[p] = 0;
    end
    s = 0;
    e_reads = 0;
    for (int i = 0; i < n; i++) begin
      int p;
      p = order[i];
      e_ok[p]  = legal(addr_a[p]);
      g_k[p]   = s + 1;
      r_k[p]   = e_ok[p] ? s + 1 + LAT : s + 1;
      e_err[p] = ~e_ok[p];
      if (e_ok[p] && !we_a[p]) begin
        e_rd[p] = ref_mem[addr_a[p] / 4];
        e_reads += LAT;
      end
      if (e_ok[p] && we_a[p]) begin
        ref_mem[addr_a[p] / 4] = wd_a[p];
        exp_w_q.push_back({8'(r_k[p] - 1), addr_a[p], wd_a[p]});
      end
      m_gnt[p]++;
      if (!e_ok[p]) m_err++;
      m_last = p;
      s = r_k[p] + 1;
    end

    apply_inputs();
    reads = 0; bad_idle = 0; bad_zero = 0; dup = 0; extra_w = 0;
    for (int k = 1; k <= s; k++) begin
      @(negedge clk);
      if (cpu_gnt_o) begin
        if (o_g[0] < 0) o_g[0] = k; else dup++;
        cpu_req_i = 1'b0;
      end
      if (dbg_gnt_o) begin
        if (o_g[1] < 0) o_g[1] = k; else dup++;
        dbg_req_i = 1'b0;
      end
      if (cpu_rvalid_o) begin
        if (o_r[0] < 0) begin o_r[0] = k; o_rd[0] = cpu_rdata_o; o_err[0] = cpu_err_o; end
        else dup++;
      end else if (cpu_rdata_o != 0 || cpu_err_o) bad_zero++;
      if (dbg_rvalid_o) begin
        if (o_r[1] < 0) begin o_r[1] = k; o_rd[1] = dbg_rdata_o; o_err[1] = dbg_err_o; end
        else dup++;
      end else if (dbg_rdata_o != 0 || dbg_err_o) bad_zero++;
      in_acc = 0;
      for (int p = 0; p < 2; p++)
        if (e_ok[p] && g_k[p] <= k && k < r_k[p]) in_acc = 1;
      if (!in_acc && (mem_read_o || mem_write_o || mem_addr_o != 0 || mem_data_o != 0))
        bad_idle++;
      if (mem_read_o) reads++;
      if (mem_write_o) begin
        if (exp_w_q.size() == 0) extra_w++;
        else begin
          w_ent = exp_w_q.pop_front();
          check("write_beat", {8'(k), mem_addr_o, mem_data_o}, w_ent);
        end
      end
    end

    for (int p = 0; p < 2; p++) begin
      check($sformatf("gnt_cycle_%s", pn(p)), 64'(o_g[p]), 64'(g_k[p]));
      check($sformatf("rvalid_cycle_%s", pn(p)), 64'(o_r[p]), 64'(r_k[p]));
      if (act_a[p]) begin
        check($sformatf("rdata_%s", pn(p)), 64'(o_rd[p]), 64'(e_rd[p]));
        check($sformatf("err_%s", pn(p)), 64'(o_err[p]), 64'(e_err[p]));
      end
    end
    check("read_cycles", 64'(reads), 64'(e_reads));
    check("missing_writes", 64'(exp_w_q.size() + extra_w), 64'(0));
    check("mem_outside_access", 64'(bad_idle), 64'(0));
    check("resp_fields_idle", 64'(bad_zero), 64'(0));
    check("duplicate_pulses", 64'(dup), 64'(0));
    check_mem();
    setp(0, 0, 0, '0, '0);
    setp(1, 0, 0, '0, '0);
  endtask

  // ---------------- both ports hold req continuously ----------------
  task automatic contention();
    logic [9:0] exp_q[$];
    logic [9:0] ent;
    int extra;
    do_reset();
    setp(0, 1, 0, 32'd8, '0);
    setp(1, 1, 0, 32'd16, '0);
    for (int j = 0; j < 4; j++) begin
      exp_q.push_back({1'b0, 1'(j % 2), 8'(1 + 4 * j)});
      exp_q.push_back({1'b1, 1'(j % 2), 8'(3 + 4 * j)});
    end
    apply_inputs();
    extra = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        logic g, v;
        logic [31:0] rd;
        g  = (p == 0) ? cpu_gnt_o : dbg_gnt_o;
        v  = (p == 0) ? cpu_rvalid_o : dbg_rvalid_o;
        rd = (p == 0) ? cpu_rdata_o : dbg_rdata_o;
        if (g) begin
          if (exp_q.size() == 0) extra++;
          else begin ent = exp_q.pop_front(); check("cont_gnt", {1'b0, 1'(p), 8'(k)}, ent); end
        end
        if (v) begin
          if (exp_q.size() == 0) extra++;
          else begin ent = exp_q.pop_front(); check("cont_rvalid", {1'b1, 1'(p), 8'(k)}, ent); end
          check($sformatf("cont_rdata_%s", pn(p)), 64'(rd), 64'(ref_mem[(p == 0) ? 2 : 4]));
        end
      end
      if (k == 16) begin cpu_req_i = 1'b0; dbg_req_i = 1'b0; end
    end
    check("cont_events_left", 64'(exp_q.size() + extra), 64'(0));
    m_last = 1; m_gnt[0] += 2; m_gnt[1] += 2;
    setp(0, 0, 0, '0, '0);
    setp(1, 0, 0, '0, '0);
  endtask

  // ---------------- reset during the first ACCESS cycle of a store ----------------
  task automatic reset_mid_access();
    wait_idle();
    setp(0, 1, 1, 32'd12, 32'hAAAA_5555);
    setp(1, 0, 0, '0, '0);
    apply_inputs();
    @(negedge clk);
    check("mid_gnt", 64'(cpu_gnt_o), 64'(1));
    check("mid_busy_access", 64'(busy_o), 64'(1));
    cpu_req_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_after_rst", {61'(0), mem_write_o, cpu_rvalid_o, busy_o}, 64'(0));
    rst_n = 1'b1;
    m_last = 1;
    m_gnt[0] = 0; m_gnt[1] = 0; m_err = 0;
    @(negedge clk);
    check("mid_quiet", {61'(0), mem_write_o, cpu_rvalid_o, dbg_rvalid_o}, 64'(0));
    check_mem();
    setp(0, 1, 0, 32'd20, '0);
    setp(1, 1, 0, 32'd24, '0);
    run_case();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < NW; i++) begin
      init_mem[i] = $urandom;
      ref_mem[i]  = init_mem[i];
    end
    init_mem[2] = 32'hDEAD_BEEF;
    ref_mem[2]  = 32'hDEAD_BEEF;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cpu", {30'(0), cpu_gnt_o, cpu_rvalid_o, cpu_rdata_o}, 64'(0));
    check("rst_dbg", {30'(0), dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o}, 64'(0));
    check("rst_mem", {mem_addr_o, mem_data_o}, 64'(0));
    check("rst_ctl", {59'(0), mem_read_o, mem_write_o, cpu_err_o, dbg_err_o, busy_o}, 64'(0));
    do_reset();

    // Directed single-port traffic.
    setp(0, 1, 0, 32'd8, '0);              run_case();
    setp(0, 1, 1, 32'd4, 32'h1234_5678);   run_case();
    setp(0, 1, 0, 32'd4, '0);              run_case();
    setp(0, 1, 0, 32'd6, '0);              run_case();
    setp(0, 1, 1, 32'd117, 32'h5A5A_5A5A); run_case();
    setp(1, 1, 1, 32'd116, 32'hCAFE_F00D); run_case();
    setp(0, 1, 0, 32'd116, '0);            run_case();
    setp(1, 1, 0, 32'hFFFF_FFFC, '0);      run_case();

    contention();
    reset_mid_access();

    // Clean tally: 3 CPU grants (one an error) and 2 DBG grants.
    do_reset();
    setp(0, 1, 0, 32'd0, '0);              run_case();
    setp(0, 1, 1, 32'd40, 32'h0BAD_CAFE);  run_case();
    setp(0, 1, 0, 32'd6, '0);              run_case();
    setp(1, 1, 0, 32'd40, '0);             run_case();
    setp(1, 1, 1, 32'd44, 32'h7777_0001);  run_case();
`ifdef DMEM_ARB_STATS_EN
    check("stat_cpu", 64'(cpu_cnt_o), 64'(3));
    check("stat_dbg", 64'(dbg_cnt_o), 64'(2));
    check("stat_err", 64'(err_cnt_o), 64'(1));
`endif

    for (int it = 0; it < 40; it++) begin
      int mode;
      mode = $urandom_range(0, 2);
      setp(0, (mode != 1), 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      setp(1, (mode != 0), 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      run_case();
    end

`ifdef DMEM_ARB_STATS_EN
    check("stat_cpu_rand", 64'(cpu_cnt_o), 64'(m_gnt[0]));
    check("stat_dbg_rand", 64'(dbg_cnt_o), 64'(m_gnt[1]));
    check("stat_err_rand", 64'(err_cnt_o), 64'(m_err));
    force dut.r_cpu_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_cpu_cnt;
    setp(0, 1, 0, 32'd0, '0);
    run_case();
    check("stat_cpu_sat", 64'(cpu_cnt_o), 64'(16'hFFFF));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
